sar_conv_host: RTL and testbench

Host-side conversion sequencer for the 8-bit SAR ADC controller. It paces conversions by issuing one-cycle `cnvst` pulses and waits for `eoc` with a timeout. On each `eoc` it captures `sar[7:0]` and averages 2^AVG_LOG2 results. The averaged word goes to the downstream system over a valid/ready handshake, so this block sits between the SAR controller and the digital back end.

---
 rtl/sar_conv_host.sv | 111 +++++++++++
 tb/tb_sar_conv_host.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sar_conv_host.sv
// sar_conv_host: conversion sequencer for the 8-bit SAR ADC controller.
// Paces cnvst pulses, waits for eoc with a timeout, averages 2^AVG_LOG2
// samples and presents the result on a valid/ready handshake.
module sar_conv_host #(
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned PERIOD   = 32,
  parameter int unsigned TIMEOUT  = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       cnvst,
  input  logic       eoc,
  input  logic [7:0] sar,
  output logic [7:0] res_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       timeout_err,
  input  logic       err_clr,
  output logic       busy
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_START    = 2'd1;
  localparam logic [1:0] S_WAIT_EOC = 2'd2;
  localparam logic [1:0] S_OUTPUT   = 2'd3;

  localparam int unsigned ACC_W = 8 + AVG_LOG2;
  localparam int unsigned SMP_W = AVG_LOG2 + 1;
  localparam int unsigned PER_W = $clog2(PERIOD);
  localparam int unsigned TO_W  = $clog2(TIMEOUT);

  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [PER_W-1:0] PER_MAX  = PER_W'(PERIOD - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [SMP_W-1:0] smp_cnt;
  logic [PER_W-1:0] per_cnt;
  logic [TO_W-1:0]  to_cnt;

  // Accumulator width covers 2^AVG_LOG2 * 255, so this sum cannot wrap.
  assign sum       = acc + ACC_W'(sar);
  assign res_valid = (state == S_OUTPUT);
  assign busy      = (state != S_IDLE);

  // Sequencer FSM with period, timeout and sample counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnvst       <= 1'b0;
      res_data    <= '0;
      timeout_err <= 1'b0;
      acc         <= '0;
      smp_cnt     <= '0;
      to_cnt      <= '0;
      per_cnt     <= PER_MAX;
    end else begin
      cnvst <= 1'b0;
      if (per_cnt != PER_MAX)
        per_cnt <= per_cnt + 1'b1;
      // A timeout later in this block overrides the clear (set wins).
      if (err_clr)
        timeout_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (enable && per_cnt == PER_MAX) begin
            // per_cnt reads 0 during the START cycle so starts are PERIOD apart.
            state   <= S_START;
            cnvst   <= 1'b1;
            per_cnt <= '0;
          end
        end
        S_START: begin
          to_cnt <= '0;
          state  <= S_WAIT_EOC;
        end
        S_WAIT_EOC: begin
          if (eoc) begin
            if (smp_cnt == SMP_LAST) begin
              res_data <= sum[ACC_W-1:AVG_LOG2];
              acc      <= '0;
              smp_cnt  <= '0;
              state    <= S_OUTPUT;
            end else begin
              acc     <= sum;
              smp_cnt <= smp_cnt + 1'b1;
              state   <= S_IDLE;
            end
          end else if (to_cnt == TO_MAX) begin
            timeout_err <= 1'b1;
            acc         <= '0;
            smp_cnt     <= '0;
            state       <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_OUTPUT: begin
          if (res_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_conv_host.sv
// Directed self-checking bench for sar_conv_host (AVG_LOG2=2 and AVG_LOG2=0).
module tb_sar_conv_host;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0, eoc = 1'b0, res_ready = 1'b0, err_clr = 1'b0;
  logic [7:0] sar = 8'h00;
  logic       cnvst, res_valid, timeout_err, busy;
  logic [7:0] res_data;

  logic       enable0 = 1'b0, eoc0 = 1'b0, res_ready0 = 1'b1, err_clr0 = 1'b0;
  logic [7:0] sar0 = 8'h00;
  logic       cnvst0, res_valid0, timeout_err0, busy0;
  logic [7:0] res_data0;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  // Counts one-cycle cnvst pulses of the main instance.
  always @(posedge clk) if (cnvst === 1'b1) pulse_cnt <= pulse_cnt + 1;

  sar_conv_host #(.AVG_LOG2(2), .PERIOD(32), .TIMEOUT(24)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cnvst(cnvst), .eoc(eoc), .sar(sar),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .timeout_err(timeout_err), .err_clr(err_clr), .busy(busy)
  );

  sar_conv_host #(.AVG_LOG2(0), .PERIOD(32), .TIMEOUT(24)) dut0 (
    .clk(clk), .rst(rst), .enable(enable0), .cnvst(cnvst0), .eoc(eoc0), .sar(sar0),
    .res_data(res_data0), .res_valid(res_valid0), .res_ready(res_ready0),
    .timeout_err(timeout_err0), .err_clr(err_clr0), .busy(busy0)
  );

  // ADC model: wait for cnvst (phase 0), then step to stop_phase, pulsing eoc
  // with val at eoc_phase (eoc_phase < 0 withholds eoc). Returns at a negedge.
  task automatic conv(input bit sel, input int eoc_phase, input logic [7:0] val,
                      input int stop_phase);
    int n;
    n = 0;
    while (((sel ? cnvst0 : cnvst) !== 1'b1) && n < 100) begin
      @(negedge clk);
      eoc = 1'b0; eoc0 = 1'b0;
      n++;
    end
    if ((sel ? cnvst0 : cnvst) !== 1'b1) begin
      checks++; failures++;
      $display("FAIL conv_wait: no cnvst within 100 cycles (sel=%0d)", sel);
      return;
    end
    for (int p = 1; p <= stop_phase; p++) begin
      @(negedge clk);
      if (sel) begin eoc0 = (p == eoc_phase); sar0 = val; end
      else     begin eoc  = (p == eoc_phase); sar  = val; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (cnvst !== 1'b0) begin failures++; $display("FAIL rst_cnvst: got %b want 0", cnvst); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", res_valid); end
    checks++; if (res_data !== 8'h00) begin failures++; $display("FAIL rst_data: got %h want 00", res_data); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b want 0", timeout_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_average();
    int pc0;
    enable = 1'b1; res_ready = 1'b0;
    pc0 = pulse_cnt;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cnvst !== 1'b1) begin failures++; $display("FAIL first_cnvst: got %b want 1", cnvst); end
    conv(1'b0, 10, 8'h10, 10);
    conv(1'b0, 10, 8'h20, 10);
    conv(1'b0, 10, 8'h30, 10);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL avg_early_valid: got %b want 0", res_valid); end
    conv(1'b0, 10, 8'h41, 11);
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL avg_valid: got %b want 1", res_valid); end
    checks++; if (res_data !== 8'h28) begin failures++; $display("FAIL avg_data: got %h want 28", res_data); end
    checks++; if (pulse_cnt - pc0 !== 4) begin failures++; $display("FAIL avg_pulses: got %0d want 4", pulse_cnt - pc0); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d]: got %b want 1", i, res_valid); end
      checks++; if (res_data !== 8'h28) begin failures++; $display("FAIL bp_data[%0d]: got %h want 28", i, res_data); end
      checks++; if (cnvst !== 1'b0) begin failures++; $display("FAIL bp_cnvst[%0d]: got %b want 0", i, cnvst); end
    end
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %b want 0", res_valid); end
    @(negedge clk);
    checks++; if (cnvst !== 1'b1) begin failures++; $display("FAIL bp_next_cnvst: got %b want 1", cnvst); end
  endtask

  task automatic test_reset_mid();
    conv(1'b0, 10, 8'h11, 10);
    conv(1'b0, 10, 8'h22, 10);
    conv(1'b0, 10, 8'h33, 10);
    conv(1'b0, -1, 8'h00, 5);
    #2 rst = 1'b1;
    #1;
    checks++; if (cnvst !== 1'b0) begin failures++; $display("FAIL mid_rst_cnvst: got %b want 0", cnvst); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b want 0", res_valid); end
    checks++; if (res_data !== 8'h00) begin failures++; $display("FAIL mid_rst_data: got %h want 00", res_data); end
    @(negedge clk);
    rst = 1'b0;
    conv(1'b0, 10, 8'h40, 10);
    conv(1'b0, 10, 8'h40, 10);
    conv(1'b0, 10, 8'h40, 10);
    conv(1'b0, 10, 8'h44, 11);
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL mid_after_valid: got %b want 1", res_valid); end
    checks++; if (res_data !== 8'h41) begin failures++; $display("FAIL mid_after_data: got %h want 41", res_data); end
  endtask

  task automatic test_period();
    int last_rise, n_rise, phase;
    bit prev, exp_busy;
    last_rise = 0; n_rise = 0; prev = 1'b0;
    enable = 1'b1; res_ready = 1'b1; eoc = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 400 && n_rise < 9; cyc++) begin
      @(negedge clk);
      if (cnvst === 1'b1 && !prev) begin
        if (n_rise > 0) begin
          checks++;
          if (cyc - last_rise != 32) begin failures++; $display("FAIL period: got %0d want 32", cyc - last_rise); end
        end
        last_rise = cyc;
        n_rise++;
      end
      phase = cyc - last_rise;
      if (n_rise > 0 && phase == 1) begin
        checks++; if (cnvst !== 1'b0) begin failures++; $display("FAIL cnvst_width: got %b want 0", cnvst); end
      end
      exp_busy = (n_rise > 0) && (phase <= 10 || (phase == 11 && (n_rise % 4) == 0));
      checks++;
      if (busy !== exp_busy) begin failures++; $display("FAIL period_busy[%0d]: got %b want %b", cyc, busy, exp_busy); end
      eoc = (n_rise > 0 && phase == 10);
      sar = 8'h5A;
      prev = cnvst;
    end
    eoc = 1'b0;
    checks++; if (n_rise != 9) begin failures++; $display("FAIL period_count: got %0d want 9", n_rise); end
  endtask

  task automatic test_timeout();
    enable = 1'b1; res_ready = 1'b1;
    do_reset();
    conv(1'b0, 10, 8'h80, 10);
    conv(1'b0, -1, 8'h00, 24);
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_early: got %b want 0", timeout_err); end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_set: got %b want 1", timeout_err); end
    conv(1'b0, 10, 8'h04, 10);
    conv(1'b0, 10, 8'h08, 10);
    conv(1'b0, 10, 8'h0C, 11);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL to_partial_kept: got %b want 0", res_valid); end
    conv(1'b0, 10, 8'h10, 11);
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL to_fresh_valid: got %b want 1", res_valid); end
    checks++; if (res_data !== 8'h0A) begin failures++; $display("FAIL to_fresh_data: got %h want 0a", res_data); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL err_clr: got %b want 0", timeout_err); end
    // eoc in the last allowed wait cycle is accepted, no timeout
    conv(1'b0, 24, 8'h55, 25);
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_boundary_err: got %b want 0", timeout_err); end
    conv(1'b0, 10, 8'h55, 10);
    conv(1'b0, 10, 8'h55, 10);
    conv(1'b0, 10, 8'h55, 11);
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL to_boundary_valid: got %b want 1", res_valid); end
    checks++; if (res_data !== 8'h55) begin failures++; $display("FAIL to_boundary_data: got %h want 55", res_data); end
    // timeout and err_clr on the same edge: set wins
    conv(1'b0, -1, 8'h00, 24);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL set_wins: got %b want 1", timeout_err); end
    enable = 1'b0;
  endtask

  task automatic test_avg0();
    logic [7:0] vals [3];
    vals[0] = 8'hFF; vals[1] = 8'h00; vals[2] = 8'h80;
    enable0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      conv(1'b1, 10, vals[i], 10);
      checks++; if (res_valid0 !== 1'b0) begin failures++; $display("FAIL avg0_pre_valid[%0d]: got %b want 0", i, res_valid0); end
      @(negedge clk);
      eoc0 = 1'b0;
      checks++; if (res_valid0 !== 1'b1) begin failures++; $display("FAIL avg0_valid[%0d]: got %b want 1", i, res_valid0); end
      checks++; if (res_data0 !== vals[i]) begin failures++; $display("FAIL avg0_data[%0d]: got %h want %h", i, res_data0, vals[i]); end
      @(negedge clk);
      checks++; if (res_valid0 !== 1'b0) begin failures++; $display("FAIL avg0_post_valid[%0d]: got %b want 0", i, res_valid0); end
    end
    enable0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_average();
    test_backpressure();
    test_reset_mid();
    test_period();
    test_timeout();
    test_avg0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
